// File: rtl/test_port_arbiter.sv
// rtl/test_port_arbiter.sv - round-robin owner of the shared TstPort word with minimum dwell.
// Optional owner preemption after MAX_HOLD cycles is enabled by defining TST_PORT_TIMEOUT_EN.
module test_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PORT_W = 16,
  parameter int MIN_HOLD = 8,
  parameter int MAX_HOLD = 256,
  parameter logic [PORT_W-1:0] IDLE_WORD = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*PORT_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        busy,
  output logic [PORT_W-1:0]           TstPort
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       hold_q, hold_d;
  logic [PORT_W-1:0]   port_q, port_d;

  logic                found;
  logic [OW-1:0]       pick;
  logic                timeout_hit;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = OW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

`ifdef TST_PORT_TIMEOUT_EN
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_HOLD - 1);
  assign timeout_hit = (state_q == S_GRANT) && (hold_q >= MAX_LAST) && (|(req & ~grant_q));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    port_d  = port_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        port_d  = IDLE_WORD;
        if (found) begin
          state_d       = S_GRANT;
          grant_d[pick] = 1'b1;
          owner_d       = pick;
          ptr_d         = (pick == OW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          hold_d        = '0;
          port_d        = req_data[pick*PORT_W +: PORT_W];
        end
      end
      S_GRANT: begin
        if (timeout_hit) begin
          state_d = S_GAP;
          grant_d = '0;
          port_d  = IDLE_WORD;
        end else if (req[owner_q]) begin
          port_d = req_data[owner_q*PORT_W +: PORT_W];
          if (hold_q != '1) hold_d = hold_q + 1'b1;
        end else if (hold_q < MIN_LAST) begin
          // Released early: keep ownership and the last captured word until dwell is met.
          hold_d = hold_q + 1'b1;
        end else begin
          state_d = S_GAP;
          grant_d = '0;
          port_d  = IDLE_WORD;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        grant_d = '0;
        port_d  = IDLE_WORD;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        port_d  = IDLE_WORD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      port_q  <= IDLE_WORD;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      port_q  <= port_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = (state_q == S_GRANT);
  assign TstPort = port_q;

endmodule

// File: doc/test_port_arbiter.md
Name: test_port_arbiter

Overview:
- Shares the single 16-bit test port bus among NUM_REQ internal requesters, e.g. debug taps, BER counters and modem status snapshots.
- Round-robin grant with level request/grant handshake and a guaranteed minimum dwell per owner.
- Drives the registered TstPort word consumed by the test-port bit pickers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PORT_W, 16, test port word width.
- MIN_HOLD, 8, minimum cycles TstPort stays owned once granted (>=1).
- MAX_HOLD, 256, owner timeout in cycles, used only with TST_PORT_TIMEOUT_EN (>=MIN_HOLD).
- IDLE_WORD, 16'h0000, value driven on TstPort when unowned.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request; bit k held high while requester k wants the port.
- req_data  in  NUM_REQ*PORT_W  word of requester k at bits [k*PORT_W +: PORT_W].
- grant  out  NUM_REQ  one-hot grant, registered, all-zero when unowned.
- owner  out  clog2(NUM_REQ)  index of current or last owner.
- busy  out  1  high while state is GRANT.
- TstPort  out  PORT_W  registered shared test port word.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at an edge), regardless of state:
  - state=IDLE, grant=0, busy=0, TstPort=IDLE_WORD, owner=0, hold_cnt=0.
  - Round-robin pointer set so requester 0 has highest priority.
- Reset mid-grant drops grant on the same edge.
- IDLE:
  - grant=0, TstPort=IDLE_WORD.
  - If any req bit is set, select the first set bit searching upward from (last owner + 1) mod NUM_REQ, wrapping.
  - Next edge: state=GRANT, grant[k]=1, owner=k, busy=1, hold_cnt=0, TstPort=req_data slice k.
  - Request to grant latency: 1 cycle from IDLE.
- GRANT:
  - While req[k]=1: TstPort <= slice k every cycle (1-cycle pipeline); hold_cnt saturates at its maximum.
  - If req[k]=0 and hold_cnt < MIN_HOLD-1: grant stays asserted, TstPort frozen at last captured word, hold_cnt increments.
  - Exit when req[k]=0 and hold_cnt >= MIN_HOLD-1: next edge state=GAP, grant=0, busy=0.
  - req changes on other bits never preempt the owner (unless timeout feature).
- GAP (exactly one cycle):
  - TstPort=IDLE_WORD, grant=0. Guarantees one idle word between owners.
  - Next edge goes to IDLE; no arbitration occurs in GAP.
- Handover timing: owner drops req at cycle t (dwell satisfied) -> GAP at t+1, IDLE at t+2, new grant visible at t+3.
- Fairness: the pointer updates on entry to GRANT; a requester that just released has lowest priority next round.
- Simultaneous requests in IDLE: the lowest index at or after the pointer wins; others keep waiting with grant=0.
- hold_cnt width is clog2(MAX_HOLD+1) and it never wraps.
- Out-of-range owner is impossible by construction.

Optional Feature:
- Macro TST_PORT_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt reaches MAX_HOLD-1 and any other req bit is set, force GAP on the next edge even if req[k]=1.
  - The preempted requester re-enters arbitration with lowest priority.
  - If no other request is pending, the owner keeps the port indefinitely.
- Undefined: no timeout logic or comparator is synthesised; the owner keeps the port until it releases.

Test Plan:
- Reset, then req=4'b0001 with slice0=16'hA5A5 -> after 1 edge grant=0001, owner=0, busy=1; next edge TstPort=16'hA5A5.
- req=4'b0110 asserted together from IDLE after reset -> grant=0010 first. Drop req[1] after 10 cycles -> 1 GAP cycle with TstPort=16'h0000, then grant=0100 at t+3.
- Owner 2 drops req after 2 cycles with MIN_HOLD=8 -> grant held for 8 cycles total; TstPort frozen at last word; then GAP.
- All four requesting continuously, each releasing after 8 cycles -> grant order 0,1,2,3,0 with no requester skipped or repeated.
- rst asserted mid-GRANT -> on that edge grant=0, TstPort=16'h0000, busy=0; next arbitration favours requester 0.
- With TST_PORT_TIMEOUT_EN, MAX_HOLD=16: owner 0 holds req with req[3] pending -> grant drops after 16 cycles, then grant=1000. Without the macro, owner 0 keeps grant for 1000 cycles.
